// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcode constants, functional-unit tags
// and the decoded-instruction record handed to dispatch.
package decode_stage_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG32  = 7'h3B;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    LSU = 2'd1,
    BU  = 2'd2
  } e_functional_unit;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
    e_functional_unit fu;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             illegal;
  } s_decoded_insn;

endpackage

// File: rtl/decode_stage_insn_decoder.sv
// Purely combinational RV64I field/immediate/unit decoder.
module insn_decoder
  import decode_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = XLEN
) (
  input  logic [31:0]   insn,
  output s_decoded_insn dec
);

  function automatic logic [ADDRESS_WIDTH-1:0] sext32(input logic [31:0] v);
    return {{(ADDRESS_WIDTH-32){v[31]}}, v};
  endfunction

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Each format is first assembled as a 32-bit value sign-extended from bit 31.
  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.opcode = insn[6:0];
    dec.rd     = insn[11:7];
    dec.funct3 = insn[14:12];
    dec.rs1    = insn[19:15];
    dec.rs2    = insn[24:20];
    dec.funct7 = insn[31:25];
    dec.fu     = ALU;
    unique case (insn[6:0])
      OP_LOAD: begin
        dec.imm = sext32(imm_i);
        dec.fu  = LSU;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OP_IMM, OP_IMM32: begin
        dec.imm = sext32(imm_i);
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OP_JALR: begin
        dec.imm = sext32(imm_i);
        dec.fu  = BU;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OP_STORE: begin
        dec.imm = sext32(imm_s);
        dec.fu  = LSU;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = sext32(imm_b);
        dec.fu  = BU;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm = sext32(imm_u);
        dec.writes_rd = 1'b1;
      end
      OP_JAL: begin
        dec.imm = sext32(imm_j);
        dec.fu  = BU;
        dec.writes_rd = 1'b1;
      end
      OP_REG, OP_REG32: begin
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (insn[11:7] == 5'd0) dec.writes_rd = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: polls the ifu, decodes each instruction and buffers the result
// in a small in-order queue presented to dispatch via valid/ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int ADDRESS_WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready_i,
  input  logic [31:0]      fetch_insn_i,
  output logic             instruction_poll_o,
  input  logic             bcast_valid_i,
  input  e_functional_unit bcast_rs_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output s_decoded_insn    dec_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  s_decoded_insn decoded;
  s_decoded_insn mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, space, redirect;

  insn_decoder #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_dec (
    .insn (fetch_insn_i),
    .dec  (decoded)
  );

  assign pop      = dec_valid_o & dec_ready_i;
  assign space    = (count < DEPTH_C) | pop;
  assign redirect = bcast_valid_i & (bcast_rs_i == BU);
  // Poll is held low while reset is asserted so nothing is consumed from the ifu.
  assign instruction_poll_o = fetch_ready_i & space & ~redirect & ~rst;
  assign push     = instruction_poll_o;

  assign dec_valid_o = (count != '0);
  assign dec_o       = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= decoded;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard of expected decoded entries.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_ready_i;
  logic [31:0]      fetch_insn_i;
  logic             instruction_poll_o;
  logic             bcast_valid_i;
  e_functional_unit bcast_rs_i;
  logic             dec_valid_o;
  logic             dec_ready_i;
  s_decoded_insn    dec_o;

  int total = 0;
  int bad   = 0;
  s_decoded_insn sb[$];
  s_decoded_insn nxt;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(2), .ADDRESS_WIDTH(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_ready_i      (fetch_ready_i),
    .fetch_insn_i       (fetch_insn_i),
    .instruction_poll_o (instruction_poll_o),
    .bcast_valid_i      (bcast_valid_i),
    .bcast_rs_i         (bcast_rs_i),
    .dec_valid_o        (dec_valid_o),
    .dec_ready_i        (dec_ready_i),
    .dec_o              (dec_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic s_decoded_insn mk(input logic [31:0] w, input logic [63:0] imm,
                                       input e_functional_unit fu, input logic r1,
                                       input logic r2, input logic wr, input logic ill);
    s_decoded_insn d;
    d           = '0;
    d.opcode    = w[6:0];
    d.rd        = w[11:7];
    d.funct3    = w[14:12];
    d.rs1       = w[19:15];
    d.rs2       = w[24:20];
    d.funct7    = w[31:25];
    d.imm       = imm;
    d.fu        = fu;
    d.uses_rs1  = r1;
    d.uses_rs2  = r2;
    d.writes_rd = wr;
    d.illegal   = ill;
    return d;
  endfunction

  // Called 1 time unit after a rising edge; samples mid-cycle, then advances one cycle.
  task automatic cyc(input logic exp_poll);
    #3;
    chk("poll", 128'(instruction_poll_o), 128'(exp_poll));
    chk("valid", 128'(dec_valid_o), 128'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head", 128'(dec_o), 128'(sb[0]));
      if (dec_ready_i) void'(sb.pop_front());
    end
    if (exp_poll) sb.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [63:0] imm, input e_functional_unit fu,
                       input logic r1, input logic r2, input logic wr, input logic ill,
                       input logic exp_poll);
    fetch_insn_i = w;
    nxt = mk(w, imm, fu, r1, r2, wr, ill);
    cyc(exp_poll);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    fetch_ready_i = 1'b0;
    fetch_insn_i  = '0;
    bcast_valid_i = 1'b0;
    bcast_rs_i    = ALU;
    dec_ready_i   = 1'b0;
    nxt = '0;
    #12;
    chk("rst_valid", 128'(dec_valid_o), 128'(0));
    chk("rst_poll", 128'(instruction_poll_o), 128'(0));
    chk("rst_dec", 128'(dec_o), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stream of formats with dispatch always ready.
    dec_ready_i   = 1'b1;
    fetch_ready_i = 1'b1;
    offer(32'h00500093, 64'd5, ALU, 1, 0, 1, 0, 1);
    offer(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, BU, 1, 1, 0, 0, 1);
    offer(32'h12345037, 64'h0000000012345000, ALU, 0, 0, 0, 0, 1);
    offer(32'hFE513C23, 64'hFFFFFFFFFFFFFFF8, LSU, 1, 1, 0, 0, 1);
    offer(32'h008000EF, 64'd8, BU, 0, 0, 1, 0, 1);
    offer(32'h002081B3, 64'd0, ALU, 1, 1, 1, 0, 1);
    offer(32'hFFFFF017, 64'hFFFFFFFFFFFFF000, ALU, 0, 0, 0, 0, 1);
    fetch_ready_i = 1'b0;
    cyc(0);
    cyc(0);

    // Backpressure: two fill the queue, the third waits at the ifu.
    dec_ready_i   = 1'b0;
    fetch_ready_i = 1'b1;
    offer(32'h00100113, 64'd1, ALU, 1, 0, 1, 0, 1);
    offer(32'h00200193, 64'd2, ALU, 1, 0, 1, 0, 1);
    offer(32'h00300213, 64'd3, ALU, 1, 0, 1, 0, 0);
    cyc(0);
    dec_ready_i = 1'b1;
    cyc(1);
    fetch_ready_i = 1'b0;
    cyc(0);
    cyc(0);
    cyc(0);

    // Branch redirect suppresses the poll; an ALU broadcast does not.
    fetch_ready_i = 1'b1;
    bcast_valid_i = 1'b1;
    bcast_rs_i    = BU;
    fetch_insn_i  = 32'h0000007F;
    #3;
    chk("poll_bu_redirect", 128'(instruction_poll_o), 128'(0));
    bcast_rs_i = ALU;
    #1;
    chk("poll_alu_bcast", 128'(instruction_poll_o), 128'(1));
    nxt = mk(32'h0000007F, 64'd0, ALU, 0, 0, 0, 1);
    #3;
    chk("poll_bcast_cycle", 128'(instruction_poll_o), 128'(1));
    chk("valid_bcast_cycle", 128'(dec_valid_o), 128'(0));
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    bcast_valid_i = 1'b0;
    fetch_ready_i = 1'b0;
    cyc(0);
    cyc(0);

    // Asynchronous reset with a full queue.
    dec_ready_i   = 1'b0;
    fetch_ready_i = 1'b1;
    offer(32'h00700293, 64'd7, ALU, 1, 0, 1, 0, 1);
    offer(32'h00800313, 64'd8, ALU, 1, 0, 1, 0, 1);
    #2;
    chk("full_valid", 128'(dec_valid_o), 128'(1));
    chk("full_poll", 128'(instruction_poll_o), 128'(0));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(dec_valid_o), 128'(0));
    chk("async_rst_poll", 128'(instruction_poll_o), 128'(0));
    chk("async_rst_dec", 128'(dec_o), 128'(0));
    sb.delete();
    fetch_ready_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 128'(dec_valid_o), 128'(0));
    @(posedge clk);
    #1;
    cyc(0);
    fetch_ready_i = 1'b1;
    offer(32'h00900393, 64'd9, ALU, 1, 0, 1, 0, 1);
    fetch_ready_i = 1'b0;
    cyc(0);
    dec_ready_i = 1'b1;
    cyc(0);
    cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
